// File: rtl/gpu_host_if_if.sv
// Host/GPU side signal bundle for gpu_host_if: command handshake, operand feed and pixel return.
// slave = the gpu_host_if block, master = whatever drives the host command and GPU strobes.
interface gpu_host_if_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_op1;
  logic [15:0] cmd_op2;
  logic [15:0] cmd_op3;
  logic        busy;
  logic        read;
  logic [15:0] op_data;
  logic        send_data;
  logic [15:0] pix_in;
  logic        busy_reset;
  logic [15:0] pix_out;
  logic        pix_valid;
  logic [15:0] pix_count;
  logic        done;
  logic        err;

  modport slave (
    input  cmd_valid, cmd_op1, cmd_op2, cmd_op3, read, send_data, pix_in, busy_reset,
    output cmd_ready, busy, op_data, pix_out, pix_valid, pix_count, done, err
  );

  modport master (
    output cmd_valid, cmd_op1, cmd_op2, cmd_op3, read, send_data, pix_in, busy_reset,
    input  cmd_ready, busy, op_data, pix_out, pix_valid, pix_count, done, err
  );
endinterface

// File: rtl/gpu_host_if.sv
// Host command to GPU control-unit bridge: feeds three operand words, collects pixels, reports done/err.
// Define GPU_HOST_TIMEOUT_EN to add a busy watchdog that aborts a stalled command after 1023 idle cycles.
module gpu_host_if (
  input  logic          clk,
  input  logic          n_reset,
  gpu_host_if_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, OP1, OP2, OP3, RUN, FINISH} state_t;

  state_t      state;
  logic [15:0] op2_q;
  logic [15:0] op3_q;
  logic        hs;
  logic        timeout;

  assign bus.cmd_ready = (state == IDLE);
  assign hs            = bus.cmd_valid && (state == IDLE);

`ifdef GPU_HOST_TIMEOUT_EN
  logic [9:0] wd_cnt;

  // Any sign of life from either side restarts the window.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      wd_cnt <= '0;
    else if (hs || bus.read || bus.send_data || bus.busy_reset)
      wd_cnt <= '0;
    else if (bus.busy)
      wd_cnt <= wd_cnt + 10'd1;
  end

  assign timeout = bus.busy && (wd_cnt == 10'h3FF);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.op_data   <= '0;
      bus.pix_out   <= '0;
      bus.pix_valid <= 1'b0;
      bus.pix_count <= '0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      op2_q         <= '0;
      op3_q         <= '0;
    end else begin
      bus.pix_valid <= 1'b0;
      bus.done      <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          op2_q         <= bus.cmd_op2;
          op3_q         <= bus.cmd_op3;
          bus.op_data   <= bus.cmd_op1;
          bus.pix_count <= '0;
          bus.err       <= 1'b0;
          bus.busy      <= 1'b1;
          state         <= OP1;
        end
        OP1, OP2, OP3: begin
          // Finishing before the operands are consumed is a protocol error.
          if (bus.busy_reset || timeout) begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= FINISH;
          end else if (state == OP1) begin
            if (bus.read) begin
              bus.op_data <= op2_q;
              state       <= OP2;
            end
          end else if (state == OP2) begin
            if (bus.read) begin
              bus.op_data <= op3_q;
              state       <= OP3;
            end
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (timeout) begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= FINISH;
          end else begin
            // A pixel arriving with busy_reset is still captured and counted.
            if (bus.send_data) begin
              bus.pix_out   <= bus.pix_in;
              bus.pix_valid <= 1'b1;
              if (bus.pix_count != 16'hFFFF)
                bus.pix_count <= bus.pix_count + 16'd1;
            end
            if (bus.busy_reset) begin
              bus.busy <= 1'b0;
              state    <= FINISH;
            end
          end
        end
        FINISH: begin
          bus.done <= !bus.err;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_host_if.sv
// Directed bench for gpu_host_if: normal flow, simultaneous finish, protocol error, ignored strobes,
// reset mid-command, pixel counter saturation and busy watchdog / no-watchdog behaviour.
module tb_gpu_host_if;
  logic clk;
  logic n_reset;
  int   tests;
  int   fails;

  gpu_host_if_if bus ();

  gpu_host_if dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake then two back-to-back reads; returns with the block in RUN.
  task automatic run_to_run(input logic [15:0] o1, input logic [15:0] o2, input logic [15:0] o3);
    bus.cmd_op1   = o1;
    bus.cmd_op2   = o2;
    bus.cmd_op3   = o3;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.read      = 1'b1;
    tick();
    tick();
    bus.read      = 1'b0;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clk = 1'b0;
    n_reset = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op1 = '0;
    bus.cmd_op2 = '0;
    bus.cmd_op3 = '0;
    bus.read = 1'b0;
    bus.send_data = 1'b0;
    bus.pix_in = '0;
    bus.busy_reset = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_busy",      bus.busy,      0);
    chk("rst_op_data",   bus.op_data,   0);
    chk("rst_pix_out",   bus.pix_out,   0);
    chk("rst_pix_valid", bus.pix_valid, 0);
    chk("rst_pix_count", bus.pix_count, 0);
    chk("rst_done",      bus.done,      0);
    chk("rst_err",       bus.err,       0);
    n_reset = 1'b1;
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);

    // Normal command flow
    bus.cmd_op1 = 16'h0011;
    bus.cmd_op2 = 16'h0022;
    bus.cmd_op3 = 16'h0033;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("n_busy",      bus.busy,      1);
    chk("n_cmd_ready", bus.cmd_ready, 0);
    chk("n_op1",       bus.op_data,   16'h0011);
    tick();
    chk("n_op1_hold",  bus.op_data,   16'h0011);
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    chk("n_op2",       bus.op_data,   16'h0022);
    tick();
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    chk("n_op3",       bus.op_data,   16'h0033);
    tick();
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    chk("n_read_run",  bus.op_data,   16'h0033);
    for (int i = 0; i < 3; i++) begin
      bus.send_data = 1'b1;
      bus.pix_in = 16'h00A0 + 16'(i);
      tick();
      chk("n_pix_out",   bus.pix_out,   16'h00A0 + 16'(i));
      chk("n_pix_valid", bus.pix_valid, 1);
      chk("n_pix_count", bus.pix_count, i + 1);
    end
    bus.send_data = 1'b0;
    tick();
    chk("n_valid_low", bus.pix_valid, 0);
    chk("n_count3",    bus.pix_count, 3);
    bus.busy_reset = 1'b1;
    tick();
    bus.busy_reset = 1'b0;
    chk("n_busy_drop", bus.busy, 0);
    chk("n_done_early", bus.done, 0);
    tick();
    chk("n_done",      bus.done,      1);
    chk("n_err",       bus.err,       0);
    chk("n_ready",     bus.cmd_ready, 1);
    tick();
    chk("n_done_pulse", bus.done, 0);

    // send_data and busy_reset together
    run_to_run(16'h0001, 16'h0002, 16'h0003);
    bus.send_data = 1'b1;
    bus.busy_reset = 1'b1;
    bus.pix_in = 16'hBEEF;
    tick();
    bus.send_data = 1'b0;
    bus.busy_reset = 1'b0;
    chk("s_pix_out",   bus.pix_out,   16'hBEEF);
    chk("s_pix_valid", bus.pix_valid, 1);
    chk("s_pix_count", bus.pix_count, 1);
    chk("s_busy",      bus.busy,      0);
    chk("s_done_early", bus.done,     0);
    tick();
    chk("s_done",      bus.done,      1);
    chk("s_valid_low", bus.pix_valid, 0);

    // busy_reset in OP2 is a protocol error; send_data in OP1 ignored
    bus.cmd_op1 = 16'h00C1;
    bus.cmd_op2 = 16'h00C2;
    bus.cmd_op3 = 16'h00C3;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.send_data = 1'b1;
    bus.pix_in = 16'h5555;
    tick();
    bus.send_data = 1'b0;
    chk("e_op1_count", bus.pix_count, 0);
    chk("e_op1_valid", bus.pix_valid, 0);
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    chk("e_op2",       bus.op_data, 16'h00C2);
    bus.busy_reset = 1'b1;
    tick();
    bus.busy_reset = 1'b0;
    chk("e_err",       bus.err,  1);
    chk("e_busy",      bus.busy, 0);
    chk("e_done0",     bus.done, 0);
    tick();
    chk("e_done1",     bus.done,      0);
    chk("e_ready",     bus.cmd_ready, 1);
    tick();
    chk("e_err_sticky", bus.err, 1);

    // cmd_valid held in RUN, strobes in IDLE ignored
    run_to_run(16'h0101, 16'h0202, 16'h0303);
    chk("b_err_clr",   bus.err, 0);
    bus.cmd_valid = 1'b1;
    tick();
    chk("b_ready_run", bus.cmd_ready, 0);
    chk("b_busy_run",  bus.busy,      1);
    tick();
    chk("b_ready_run2", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b0;
    bus.busy_reset = 1'b1;
    tick();
    bus.busy_reset = 1'b0;
    tick();
    chk("b_done",      bus.done, 1);
    bus.read = 1'b1;
    bus.send_data = 1'b1;
    bus.pix_in = 16'h1234;
    tick();
    bus.read = 1'b0;
    bus.send_data = 1'b0;
    chk("b_idle_op",    bus.op_data,   16'h0303);
    chk("b_idle_count", bus.pix_count, 0);
    chk("b_idle_valid", bus.pix_valid, 0);
    chk("b_idle_pix",   bus.pix_out,   16'hBEEF);
    chk("b_idle_busy",  bus.busy,      0);

    // Reset mid-operation after 5 pixels
    run_to_run(16'h0007, 16'h0008, 16'h0009);
    for (int i = 0; i < 5; i++) begin
      bus.send_data = 1'b1;
      bus.pix_in = 16'h0010 + 16'(i);
      tick();
    end
    bus.send_data = 1'b0;
    chk("r_count5", bus.pix_count, 5);
    n_reset = 1'b0;
    #1;
    chk("r_busy",    bus.busy,      0);
    chk("r_count",   bus.pix_count, 0);
    chk("r_done",    bus.done,      0);
    chk("r_op_data", bus.op_data,   0);
    chk("r_ready",   bus.cmd_ready, 1);
    tick();
    n_reset = 1'b1;
    tick();
    chk("r_done_after", bus.done, 0);
    chk("r_busy_after", bus.busy, 0);

    // pix_count saturates at FFFF
    run_to_run(16'h0001, 16'h0002, 16'h0003);
    bus.send_data = 1'b1;
    bus.pix_in = 16'h7777;
    repeat (65535) tick();
    chk("sat_max", bus.pix_count, 16'hFFFF);
    tick();
    chk("sat_hold",  bus.pix_count, 16'hFFFF);
    chk("sat_valid", bus.pix_valid, 1);
    bus.send_data = 1'b0;
    bus.busy_reset = 1'b1;
    tick();
    bus.busy_reset = 1'b0;
    tick();
    chk("sat_done", bus.done, 1);

`ifdef GPU_HOST_TIMEOUT_EN
    // Watchdog fires after 1023 silent busy cycles
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("w_busy_rise", bus.busy, 1);
    repeat (1023) tick();
    chk("w_busy_hold", bus.busy, 1);
    chk("w_err_hold",  bus.err,  0);
    tick();
    chk("w_busy", bus.busy, 0);
    chk("w_err",  bus.err,  1);
    chk("w_done0", bus.done, 0);
    tick();
    chk("w_done1", bus.done,      0);
    chk("w_ready", bus.cmd_ready, 1);
`else
    // Without the watchdog, busy holds until busy_reset
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (1100) tick();
    chk("nw_busy", bus.busy, 1);
    chk("nw_err",  bus.err,  0);
    bus.busy_reset = 1'b1;
    tick();
    bus.busy_reset = 1'b0;
    chk("nw_busy_drop", bus.busy, 0);
    tick();
    chk("nw_done0", bus.done,      0);
    chk("nw_ready", bus.cmd_ready, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gpu_host_if.md
GPU_HOST_IF -- requirements
Module: gpu_host_if

Interface
REQ-001 SHALL have clk, input, 1, system clock, rising-edge active.
REQ-002 SHALL have n_reset, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have cmd_valid, input, 1, host offers a shape command.
REQ-004 SHALL have cmd_ready, output, 1, block accepts a command this cycle.
REQ-005 SHALL have cmd_op1, cmd_op2 and cmd_op3, each input, 16, the three operand words of a command.
REQ-006 SHALL have busy, output, 1, command pending to the GPU control unit.
REQ-007 SHALL have read, input, 1, GPU request for the next operand word.
REQ-008 SHALL have op_data, output, 16, current operand word presented to the GPU.
REQ-009 SHALL have send_data, input, 1, GPU pixel-strobe, one pixel per high cycle.
REQ-010 SHALL have pix_in, input, 16, pixel word qualified by send_data.
REQ-011 SHALL have busy_reset, input, 1, GPU signals the shape is complete.
REQ-012 SHALL have pix_out, output, 16, captured pixel word.
REQ-013 SHALL have pix_valid, output, 1, pix_out is valid, one-cycle pulse.
REQ-014 SHALL have pix_count, output, 16, pixels received for the current command.
REQ-015 SHALL have done, output, 1, command complete, one-cycle pulse.
REQ-016 SHALL have err, output, 1, protocol error, sticky.

Function
REQ-017 SHALL implement the states IDLE, OP1, OP2, OP3, RUN and FINISH.
REQ-018 SHALL drive cmd_ready=1 only in IDLE.
REQ-019 SHALL perform a handshake when cmd_valid&cmd_ready, with the following effects:
- latch all three operands;
- load op_data=cmd_op1;
- clear pix_count and err;
- go to OP1.
REQ-020 SHALL register busy, high in OP1, OP2, OP3 and RUN, so it rises the cycle after the handshake.
REQ-021 SHALL, on read in OP1, go to OP2 and set op_data=op2 on the following cycle.
REQ-022 SHALL, on read in OP2, go to OP3 and set op_data=op3 on the following cycle.
REQ-023 SHALL advance from OP3 to RUN unconditionally after one cycle.
REQ-024 SHALL ignore read in OP3, RUN, FINISH and IDLE, leaving op_data unchanged.
REQ-025 SHALL, on send_data in RUN, register pix_out=pix_in, pulse pix_valid and increment pix_count on the next cycle.
REQ-026 SHALL saturate pix_count at 16'hFFFF with no wrap.
REQ-027 SHALL, on busy_reset in RUN, go to FINISH.
REQ-028 SHALL deassert busy the cycle after busy_reset is sampled.
REQ-029 SHALL, in FINISH, pulse done for one cycle and return to IDLE.
REQ-030 SHALL, when send_data and busy_reset are high in the same RUN cycle, capture the pixel and count it before finishing.
REQ-031 SHALL handle busy_reset in OP1, OP2 or OP3 as a protocol error:
- set err=1;
- go to FINISH;
- do not pulse done;
- drop busy.
REQ-032 SHALL ignore send_data outside RUN, with no capture and no count.
REQ-033 SHALL retain err until the next handshake.
REQ-034 SHALL require command latency of at least 4 cycles from handshake to the earliest possible done.

Reset
REQ-035 SHALL, on n_reset low at any time, force the following values:
- state=IDLE;
- busy=0;
- op_data=0;
- pix_out=0;
- pix_valid=0;
- pix_count=0;
- done=0;
- err=0.
REQ-036 SHALL drive cmd_ready=1 immediately once reset is released.
REQ-037 SHALL discard any in-flight command on reset mid-operation, with no done pulse.

Configuration
REQ-038 SHALL include a busy watchdog when GPU_HOST_TIMEOUT_EN is defined, behaving as follows:
- a 10-bit counter clears on handshake, read, send_data or busy_reset;
- the counter increments while busy=1;
- on reaching 1023, set err=1, drop busy and go to FINISH with no done pulse.
REQ-039 SHALL synthesize no watchdog logic when GPU_HOST_TIMEOUT_EN is undefined, so busy stays high indefinitely until busy_reset.

Verification
REQ-040 SHALL cover normal command flow:
- stimulus: cmd 0x0011/0x0022/0x0033, read pulses 2 cycles apart, 3 send_data pulses with pix_in 0xA0..0xA2, then busy_reset;
- response: op_data sequence 0x0011→0x0022→0x0033, pix_count=3, done pulse, err=0.
REQ-041 SHALL cover simultaneous events:
- stimulus: send_data and busy_reset in the same cycle, pix_in=0xBEEF;
- response: pix_out=0xBEEF, pix_valid pulse, pix_count incremented, done one cycle later.
REQ-042 SHALL cover the early-finish protocol error:
- stimulus: busy_reset in OP2;
- response: err=1, done=0, busy=0 next cycle, cmd_ready=1 afterwards.
REQ-043 SHALL cover ignored back-pressure and strobes:
- stimulus: cmd_valid held high during RUN, plus an extra read and send_data while in IDLE;
- response: cmd_ready=0 during RUN, no op_data change and no pix_count change in IDLE.
REQ-044 SHALL cover reset mid-operation:
- stimulus: n_reset low in RUN after 5 pixels;
- response: busy, pix_count and done all 0 immediately.
REQ-045 SHALL cover the watchdog with GPU_HOST_TIMEOUT_EN defined:
- stimulus: no GPU activity for 1023 cycles after busy rises;
- response: err=1, busy=0, no done pulse.
